// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory fetch unit.
// Optional parity protection is controlled by IMEM_PARITY_EN (see imem_fetch_unit).
package imem_pkg;

  typedef enum logic [1:0] {
    FLT_NONE,
    FLT_MISALIGN,
    FLT_RANGE,
    FLT_PARITY
  } fault_e;

  typedef enum logic [1:0] {
    IDLE,
    LOADING,
    READY
  } state_e;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  // Even parity: stored bit makes the total count of ones in byte+bit even.
  function automatic logic even_par(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/imem_byte_array.sv
// Byte-wide storage: one byte write port, one registered big-endian 4-byte read port.
// With IMEM_PARITY_EN defined, a parity bit is stored alongside each byte.
module imem_byte_array #(
  parameter int unsigned DEPTH_BYTES = 1024,
  localparam int unsigned AW = $clog2(DEPTH_BYTES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
`ifdef IMEM_PARITY_EN
  input  logic          wpar,
  output logic [3:0]    rpar,
`endif
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [7:0] mem [DEPTH_BYTES];
  logic [AW-1:0] a1, a2, a3;

  assign a1 = raddr + AW'(1);
  assign a2 = raddr + AW'(2);
  assign a3 = raddr + AW'(3);

  // Storage is intentionally not reset; only the read register is.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rdata <= '0;
    else if (re) rdata <= {mem[raddr], mem[a1], mem[a2], mem[a3]};
  end

`ifdef IMEM_PARITY_EN
  logic par [DEPTH_BYTES];

  always_ff @(posedge clk) begin
    if (we) par[waddr] <= wpar;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rpar <= '0;
    else if (re) rpar <= {par[raddr], par[a1], par[a2], par[a3]};
  end
`endif

endmodule

// File: rtl/imem_fetch_unit.sv
// Instruction memory with byte-streaming loader FSM and 1-cycle fetch port.
// Define IMEM_PARITY_EN to add per-byte parity and the parity_inject port.
module imem_fetch_unit
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH_BYTES = 1024,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned CNT_W       = $clog2(DEPTH_BYTES) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [7:0]        load_byte,
  output logic              load_ready,
  input  logic              load_done,
  output logic [CNT_W-1:0]  load_count,
  output logic              load_overflow,
  input  logic              fetch_req_valid,
  output logic              fetch_req_ready,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_resp_valid,
  output logic [31:0]       fetch_instr,
`ifdef IMEM_PARITY_EN
  input  logic              parity_inject,
`endif
  output logic [1:0]        fetch_fault
);

  localparam int unsigned AW = $clog2(DEPTH_BYTES);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH_BYTES);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q;
  logic             ovf_q;
  logic             wr_en, accept;
  logic [ADDR_W:0]  addr_end;
  fault_e           fault_d, fault_q, fault_out;
  logic             resp_valid_q;
  logic [31:0]      rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // load_start from any state restarts the load, overriding load_done.
  always_comb begin
    state_d = state_q;
    if (load_start) begin
      state_d = LOADING;
    end else begin
      case (state_q)
        LOADING: if (load_done) state_d = READY;
        default: state_d = state_q;
      endcase
    end
  end

  assign load_ready      = (state_q == LOADING) && (count_q < DEPTH_C);
  assign wr_en           = load_valid && load_ready && !load_start;
  assign fetch_req_ready = (state_q == READY);
  assign accept          = fetch_req_valid && fetch_req_ready;
  assign load_count      = count_q;
  assign load_overflow   = ovf_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (load_start) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (state_q == LOADING && load_valid) begin
      if (load_ready) count_q <= count_q + CNT_W'(1);
      else            ovf_q   <= 1'b1;
    end
  end

  // End address computed one bit wider so addresses near the top cannot wrap into range.
  assign addr_end = {1'b0, fetch_addr} + (ADDR_W+1)'(3);

  always_comb begin
    fault_d = FLT_NONE;
    if (fetch_addr[1:0] != 2'b00)                fault_d = FLT_MISALIGN;
    else if (addr_end >= (ADDR_W+1)'(count_q))   fault_d = FLT_RANGE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_valid_q <= 1'b0;
      fault_q      <= FLT_NONE;
    end else begin
      resp_valid_q <= accept;
      if (accept) fault_q <= fault_d;
    end
  end

`ifdef IMEM_PARITY_EN
  logic [3:0] rpar;
  logic       par_err;

  imem_byte_array #(.DEPTH_BYTES(DEPTH_BYTES)) u_array (
    .clk   (clk),
    .reset (reset),
    .we    (wr_en),
    .waddr (count_q[AW-1:0]),
    .wdata (load_byte),
    .wpar  (even_par(load_byte) ^ parity_inject),
    .rpar  (rpar),
    .re    (accept),
    .raddr (fetch_addr[AW-1:0]),
    .rdata (rdata)
  );

  assign par_err = rpar != {even_par(rdata[31:24]), even_par(rdata[23:16]),
                            even_par(rdata[15:8]),  even_par(rdata[7:0])};

  // Parity is only known after the read, so it ranks below the registered faults.
  always_comb begin
    fault_out = fault_q;
    if (fault_q == FLT_NONE && par_err) fault_out = FLT_PARITY;
  end
`else
  imem_byte_array #(.DEPTH_BYTES(DEPTH_BYTES)) u_array (
    .clk   (clk),
    .reset (reset),
    .we    (wr_en),
    .waddr (count_q[AW-1:0]),
    .wdata (load_byte),
    .re    (accept),
    .raddr (fetch_addr[AW-1:0]),
    .rdata (rdata)
  );

  always_comb begin
    fault_out = fault_q;
  end
`endif

  assign fetch_resp_valid = resp_valid_q;
  assign fetch_fault      = fault_out;
  assign fetch_instr      = (fault_out == FLT_NONE) ? rdata : NOP_INSTR;

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Self-checking bench for imem_fetch_unit against a byte-array reference model.
// Parity scenarios run only when IMEM_PARITY_EN is defined.
module tb_imem_fetch_unit;
  import imem_pkg::*;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk, reset;
  logic          load_start, load_valid, load_done, load_ready, load_overflow;
  logic [7:0]    load_byte;
  logic [CW-1:0] load_count;
  logic          fetch_req_valid, fetch_req_ready, fetch_resp_valid;
  logic [31:0]   fetch_addr, fetch_instr;
  logic [1:0]    fetch_fault;
  logic          parity_inject;

  imem_fetch_unit #(.DEPTH_BYTES(DEPTH), .ADDR_W(32)) dut (
    .clk              (clk),
    .reset            (reset),
    .load_start       (load_start),
    .load_valid       (load_valid),
    .load_byte        (load_byte),
    .load_ready       (load_ready),
    .load_done        (load_done),
    .load_count       (load_count),
    .load_overflow    (load_overflow),
    .fetch_req_valid  (fetch_req_valid),
    .fetch_req_ready  (fetch_req_ready),
    .fetch_addr       (fetch_addr),
    .fetch_resp_valid (fetch_resp_valid),
    .fetch_instr      (fetch_instr),
`ifdef IMEM_PARITY_EN
    .parity_inject    (parity_inject),
`endif
    .fetch_fault      (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain byte image, count, overflow flag and mode (0 idle, 1 loading, 2 ready).
  logic [7:0] m_mem  [DEPTH];
  bit         m_pbad [DEPTH];
  int         m_count;
  bit         m_ovf;
  int         m_mode;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag);
    check({tag, "_count"}, 64'(load_count), 64'(m_count));
    check({tag, "_ovf"}, 64'(load_overflow), 64'(m_ovf));
    check({tag, "_freq_rdy"}, 64'(fetch_req_ready), 64'(m_mode == 2));
    check({tag, "_load_rdy"}, 64'(load_ready), 64'(m_mode == 1 && m_count < int'(DEPTH)));
  endtask

  function automatic logic [33:0] model_fetch(input logic [31:0] a);
    logic [31:0] w;
    bit          bad;
    if (a % 4 != 0) return {FLT_MISALIGN, NOP_INSTR};
    if (longint'(a) + 3 >= longint'(m_count)) return {FLT_RANGE, NOP_INSTR};
    w   = '0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      w   = (w << 8) | 32'(m_mem[int'(a) + i]);
      bad = bad | m_pbad[int'(a) + i];
    end
    if (bad) return {FLT_PARITY, NOP_INSTR};
    return {FLT_NONE, w};
  endfunction

  task automatic begin_load();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    m_mode = 1; m_count = 0; m_ovf = 0;
    check_status("start");
  endtask

  task automatic send_byte(input logic [7:0] b, input bit inj, input bit done);
    load_valid = 1'b1; load_byte = b; load_done = done; parity_inject = inj;
    step();
    load_valid = 1'b0; load_done = 1'b0; parity_inject = 1'b0;
    if (m_count < int'(DEPTH)) begin
      m_mem[m_count]  = b;
      m_pbad[m_count] = inj;
      m_count++;
    end else begin
      m_ovf = 1;
    end
    if (done) m_mode = 2;
    check_status("load");
  endtask

  task automatic finish_load();
    load_done = 1'b1;
    step();
    load_done = 1'b0;
    m_mode = 2;
    check_status("done");
  endtask

  task automatic load_random(input int n, input bit done_with_last);
    begin_load();
    for (int i = 0; i < n; i++)
      send_byte(8'($urandom), 1'b0, done_with_last && (i == n - 1));
    if (!done_with_last) finish_load();
  endtask

  task automatic fetch_one(input logic [31:0] a, input string tag);
    logic [33:0] e;
    e = model_fetch(a);
    fetch_req_valid = 1'b1; fetch_addr = a;
    step();
    fetch_req_valid = 1'b0;
    check({tag, "_valid"}, 64'(fetch_resp_valid), 64'd1);
    check({tag, "_instr"}, 64'(fetch_instr), 64'(e[31:0]));
    check({tag, "_fault"}, 64'(fetch_fault), 64'(e[33:32]));
  endtask

  initial begin
    logic [7:0]  img [8];
    logic [33:0] e;
    logic [31:0] a;
    img = '{8'h00, 8'hF0, 8'h00, 8'h93, 8'h00, 8'h00, 8'h00, 8'h00};
    reset = 1'b1; load_start = 0; load_valid = 0; load_done = 0; load_byte = 0;
    fetch_req_valid = 0; fetch_addr = 0; parity_inject = 0;
    m_count = 0; m_ovf = 0; m_mode = 0;
    for (int i = 0; i < int'(DEPTH); i++) m_pbad[i] = 0;
    step(); step();
    reset = 1'b0;
    step();
    check_status("reset");
    check("reset_resp_valid", 64'(fetch_resp_valid), 64'd0);
    check("reset_instr", 64'(fetch_instr), 64'd0);
    check("reset_fault", 64'(fetch_fault), 64'(FLT_NONE));

    // Directed image; last byte arrives together with load_done.
    begin_load();
    for (int i = 0; i < 8; i++) send_byte(img[i], 1'b0, i == 7);
    check("img_count", 64'(load_count), 64'd8);
    fetch_one(32'h0, "f0");
    check("f0_word", 64'(fetch_instr), 64'h00F00093);
    fetch_one(32'h2, "f2");
    check("f2_fault", 64'(fetch_fault), 64'(FLT_MISALIGN));
    fetch_one(32'h8, "f8");
    check("f8_fault", 64'(fetch_fault), 64'(FLT_RANGE));
    fetch_one(32'h4, "f4");
    check("f4_word", 64'(fetch_instr), 64'h0);
    fetch_one(32'hFFFF_FFFC, "fwrap");
    fetch_one(32'h4, "f4b");
    step();
    check("idle_resp_valid", 64'(fetch_resp_valid), 64'd0);

    // Back-to-back fetches over a fresh image.
    load_random(32, 1'b0);
    fetch_req_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      fetch_addr = 32'(i * 4);
      e = model_fetch(fetch_addr);
      step();
      check("b2b_valid", 64'(fetch_resp_valid), 64'd1);
      check("b2b_instr", 64'(fetch_instr), 64'(e[31:0]));
      check("b2b_fault", 64'(fetch_fault), 64'(e[33:32]));
    end
    fetch_req_valid = 1'b0;
    step();
    check("b2b_end_valid", 64'(fetch_resp_valid), 64'd0);

    // Randomised images and fetch addresses.
    for (int r = 0; r < 6; r++) begin
      int n;
      n = int'($urandom_range(1, 96));
      load_random(n, ($urandom % 2) == 1);
      for (int k = 0; k < 20; k++) begin
        a = 32'($urandom_range(0, n + 8));
        if ($urandom_range(0, 3) != 0) a = a & ~32'h3;
        if ($urandom_range(0, 9) == 0) a = 32'hFFFF_FFFC - 32'($urandom_range(0, 7));
        fetch_one(a, "rnd");
      end
    end

    // load_start in the same cycle as a fetch accept: fetch served from old image.
    e = model_fetch(32'h4);
    fetch_req_valid = 1'b1; fetch_addr = 32'h4; load_start = 1'b1;
    step();
    load_start = 1'b0;
    check("ovl_valid", 64'(fetch_resp_valid), 64'd1);
    check("ovl_instr", 64'(fetch_instr), 64'(e[31:0]));
    check("ovl_fault", 64'(fetch_fault), 64'(e[33:32]));
    m_mode = 1; m_count = 0; m_ovf = 0;
    check_status("ovl");
    // Fetch stays requested during the load and must never be accepted.
    for (int i = 0; i < 4; i++) begin
      send_byte(8'($urandom), 1'b0, 1'b0);
      check("ldfetch_resp", 64'(fetch_resp_valid), 64'd0);
    end
    load_start = 1'b1; load_done = 1'b1;
    step();
    load_start = 1'b0; load_done = 1'b0;
    m_count = 0;
    check_status("start_done");
    check("start_done_resp", 64'(fetch_resp_valid), 64'd0);
    fetch_req_valid = 1'b0;
    send_byte(8'h5A, 1'b0, 1'b0);
    send_byte(8'hA5, 1'b0, 1'b0);
    // Asynchronous reset mid-load.
    #2 reset = 1'b1;
    #1;
    m_mode = 0; m_count = 0; m_ovf = 0;
    check_status("arst");
    check("arst_resp", 64'(fetch_resp_valid), 64'd0);
    step();
    reset = 1'b0;
    step();
    check_status("arst_post");

    // Overflow: DEPTH+2 bytes offered.
    begin_load();
    for (int i = 0; i < int'(DEPTH) + 2; i++) send_byte(8'($urandom), 1'b0, 1'b0);
    finish_load();
    check("ovf_flag", 64'(load_overflow), 64'd1);
    check("ovf_count", 64'(load_count), 64'(DEPTH));
    fetch_one(32'(DEPTH - 4), "last");
    fetch_one(32'(DEPTH - 8), "last8");
    fetch_one(32'(DEPTH - 3), "last_mis");
    fetch_one(32'(DEPTH), "past_end");
    begin_load();
    check("ovf_cleared", 64'(load_overflow), 64'd0);
    finish_load();

`ifdef IMEM_PARITY_EN
    begin_load();
    for (int i = 0; i < 8; i++) send_byte(img[i], i == 5, 1'b0);
    finish_load();
    fetch_one(32'h4, "par4");
    check("par4_fault", 64'(fetch_fault), 64'(FLT_PARITY));
    fetch_one(32'h0, "par0");
    check("par0_fault", 64'(fetch_fault), 64'(FLT_NONE));
    fetch_one(32'h5, "par_mis");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
